// File: rtl/pulse_spacer_if.sv
// Pulse spacer bus: input events and flush toward the spacer, spaced events
// and status back toward the producer.
interface pulse_spacer_if #(
  parameter int unsigned CNT_WIDTH = 4
);
  logic                 flush;
  logic                 in_pulse;
  logic                 out_pulse;
  logic [CNT_WIDTH-1:0] pending;
  logic                 busy;
  logic                 overflow;

  modport master (
    output flush,
    output in_pulse,
    input  out_pulse,
    input  pending,
    input  busy,
    input  overflow
  );

  modport slave (
    input  flush,
    input  in_pulse,
    output out_pulse,
    output pending,
    output busy,
    output overflow
  );
endinterface

// File: rtl/pulse_spacer.sv
// Source-domain pulse spacer: re-emits 1-cycle input events at least MIN_GAP
// cycles apart so a downstream toggle synchronizer always sees a legal period.
// Excess events wait in a pending counter; events beyond its capacity are
// dropped and reported on overflow.
module pulse_spacer #(
  parameter int unsigned MIN_GAP   = 2,
  parameter int unsigned CNT_WIDTH = 4
) (
  input logic           clk,
  input logic           reset,
  pulse_spacer_if.slave ps
);

  localparam int unsigned GAP_W = ($clog2(MIN_GAP) > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [GAP_W-1:0]     GAP_LOAD = GAP_W'(MIN_GAP - 1);
  localparam logic [CNT_WIDTH-1:0] PEND_MAX = '1;

  logic [GAP_W-1:0]     gap_cnt;
  logic [CNT_WIDTH-1:0] pend_q;
  logic                 out_q;
  logic                 ovf_q;
  logic                 issue;
  logic                 accept;

  // Issue when the spacing window has expired and an event is available;
  // a full queue can still take a new event in the same cycle one leaves.
  always_comb begin
    issue  = !ps.flush && (gap_cnt == '0) && ((pend_q != '0) || ps.in_pulse);
    accept = ps.in_pulse && !ps.flush && ((pend_q != PEND_MAX) || issue);
  end

  // Spacing counter, pending count and registered event/overflow pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_cnt <= '0;
      pend_q  <= '0;
      out_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      out_q <= issue;
      ovf_q <= ps.in_pulse && !ps.flush && !accept;

      // flush leaves gap_cnt alone so spacing from the last issued pulse holds.
      if (issue) begin
        gap_cnt <= GAP_LOAD;
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end

      if (ps.flush) begin
        pend_q <= '0;
      end else if (accept && !issue) begin
        pend_q <= pend_q + CNT_WIDTH'(1);
      end else if (!accept && issue) begin
        pend_q <= pend_q - CNT_WIDTH'(1);
      end
    end
  end

  assign ps.out_pulse = out_q;
  assign ps.overflow  = ovf_q;
  assign ps.pending   = pend_q;
  assign ps.busy      = (pend_q != '0) || (gap_cnt != '0);

endmodule

// File: tb/tb_pulse_spacer.sv
// Bench for pulse_spacer: four instances with different MIN_GAP/CNT_WIDTH share
// one stimulus stream; each is compared every cycle against a timestamp-based
// reference model, with directed scenarios and a random soak on top.
module tb_pulse_spacer;

  logic clk;
  logic reset;
  logic drv_in;
  logic drv_fl;

  pulse_spacer_if #(.CNT_WIDTH(4)) ifa ();
  pulse_spacer_if #(.CNT_WIDTH(2)) ifb ();
  pulse_spacer_if #(.CNT_WIDTH(4)) ifc ();
  pulse_spacer_if #(.CNT_WIDTH(4)) ifd ();

  assign ifa.in_pulse = drv_in;
  assign ifa.flush    = drv_fl;
  assign ifb.in_pulse = drv_in;
  assign ifb.flush    = drv_fl;
  assign ifc.in_pulse = drv_in;
  assign ifc.flush    = drv_fl;
  assign ifd.in_pulse = drv_in;
  assign ifd.flush    = drv_fl;

  pulse_spacer #(.MIN_GAP(2), .CNT_WIDTH(4)) u_a (.clk(clk), .reset(reset), .ps(ifa));
  pulse_spacer #(.MIN_GAP(8), .CNT_WIDTH(2)) u_b (.clk(clk), .reset(reset), .ps(ifb));
  pulse_spacer #(.MIN_GAP(4), .CNT_WIDTH(4)) u_c (.clk(clk), .reset(reset), .ps(ifc));
  pulse_spacer #(.MIN_GAP(1), .CNT_WIDTH(4)) u_d (.clk(clk), .reset(reset), .ps(ifd));

  logic       out_v  [4];
  logic       ovf_v  [4];
  logic       busy_v [4];
  logic [3:0] pend_v [4];

  assign out_v[0]  = ifa.out_pulse;
  assign out_v[1]  = ifb.out_pulse;
  assign out_v[2]  = ifc.out_pulse;
  assign out_v[3]  = ifd.out_pulse;
  assign ovf_v[0]  = ifa.overflow;
  assign ovf_v[1]  = ifb.overflow;
  assign ovf_v[2]  = ifc.overflow;
  assign ovf_v[3]  = ifd.overflow;
  assign busy_v[0] = ifa.busy;
  assign busy_v[1] = ifb.busy;
  assign busy_v[2] = ifc.busy;
  assign busy_v[3] = ifd.busy;
  assign pend_v[0] = ifa.pending;
  assign pend_v[1] = {2'b00, ifb.pending};
  assign pend_v[2] = ifc.pending;
  assign pend_v[3] = ifd.pending;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int gap_p [4] = '{2, 8, 4, 1};
  int max_p [4] = '{15, 3, 15, 15};

  // Reference model: pending count plus the earliest cycle the next issue may occur.
  int   m_pend [4];
  int   m_next [4];
  logic e_out  [4];
  logic e_ovf  [4];

  // Event bookkeeping from observed DUT outputs, for the conservation invariant.
  int n_in;
  int o_iss  [4];
  int o_drop [4];
  int o_fl   [4];

  int cyc;
  int n_cmp;
  int n_bad;

  task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s inst%0d cycle %0d: observed %0d expected %0d", tag, inst, cyc, obs, exp);
    end
  endtask

  task automatic clear_model();
    n_in = 0;
    for (int i = 0; i < 4; i++) begin
      m_pend[i] = 0;
      m_next[i] = 0;
      o_iss[i]  = 0;
      o_drop[i] = 0;
      o_fl[i]   = 0;
    end
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_out"}, i, out_v[i], 0);
      chk({tag, "_ovf"}, i, ovf_v[i], 0);
      chk({tag, "_pend"}, i, pend_v[i], 0);
      chk({tag, "_busy"}, i, busy_v[i], 0);
    end
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    drv_in = 1'b0;
    drv_fl = 1'b0;
    #1;
    check_zero("rst");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    clear_model();
  endtask

  // One clock cycle: apply inputs, advance model, compare every instance.
  task automatic step(input logic in, input logic fl);
    int pb [4];
    drv_in = in;
    drv_fl = fl;
    for (int i = 0; i < 4; i++) pb[i] = int'(pend_v[i]);
    @(posedge clk);
    if (in) n_in++;
    for (int i = 0; i < 4; i++) begin
      logic ready, iss, acc;
      ready = (cyc >= m_next[i]);
      iss   = !fl && ready && ((m_pend[i] > 0) || in);
      acc   = in && !fl && ((m_pend[i] < max_p[i]) || iss);
      e_out[i] = iss;
      e_ovf[i] = in && !fl && !acc;
      if (fl) m_pend[i] = 0;
      else    m_pend[i] = m_pend[i] + int'(acc) - int'(iss);
      if (iss) m_next[i] = cyc + gap_p[i];
      if (fl) o_fl[i] += pb[i] + int'(in);
    end
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      o_iss[i]  += int'(out_v[i]);
      o_drop[i] += int'(ovf_v[i]);
      chk("out", i, out_v[i], e_out[i]);
      chk("ovf", i, ovf_v[i], e_ovf[i]);
      chk("pend", i, pend_v[i], m_pend[i]);
      chk("busy", i, busy_v[i], (m_pend[i] > 0) || (cyc < m_next[i]));
    end
  endtask

  task automatic check_invariant(input string tag);
    for (int i = 0; i < 4; i++)
      chk(tag, i, o_iss[i] + int'(pend_v[i]) + o_drop[i] + o_fl[i], n_in);
  endtask

  initial begin
    int c1;
    int maxp;
    cyc   = 0;
    n_cmp = 0;
    n_bad = 0;
    clear_model();

    // T1: lone pulse on MIN_GAP=2
    do_reset();
    for (int c = 0; c < 16; c++) begin
      step(c == 10, 1'b0);
      c1 = c + 1;
      chk("T1_out", 0, out_v[0], c1 == 11);
      chk("T1_pend", 0, pend_v[0], 0);
      if (c1 == 11) chk("T1_busy", 0, busy_v[0], 1);
    end
    check_invariant("T1_inv");

    // T2: burst of 5 on MIN_GAP=2
    do_reset();
    maxp = 0;
    for (int c = 0; c < 24; c++) begin
      step(c >= 10 && c <= 14, 1'b0);
      c1 = c + 1;
      chk("T2_out", 0, out_v[0], c1 >= 11 && c1 <= 19 && (c1 % 2) == 1);
      chk("T2_ovf", 0, ovf_v[0], 0);
      if (int'(pend_v[0]) > maxp) maxp = int'(pend_v[0]);
    end
    chk("T2_pmax", 0, maxp, 2);
    check_invariant("T2_inv");

    // T3: saturation on MIN_GAP=8, CNT_WIDTH=2
    do_reset();
    for (int c = 0; c < 34; c++) begin
      step(c <= 5, 1'b0);
      c1 = c + 1;
      chk("T3_out", 1, out_v[1], c1 <= 25 && ((c1 - 1) % 8) == 0);
      chk("T3_ovf", 1, ovf_v[1], c1 == 5 || c1 == 6);
      if (c1 == 4) chk("T3_pend4", 1, pend_v[1], 3);
    end
    check_invariant("T3_inv");

    // T4: flush on MIN_GAP=4 keeps spacing
    do_reset();
    for (int c = 0; c < 16; c++) begin
      step((c <= 3) || (c == 7), c == 5);
      c1 = c + 1;
      chk("T4_out", 2, out_v[2], c1 inside {1, 5, 9});
      if (c1 == 6) chk("T4_pend6", 2, pend_v[2], 0);
    end
    check_invariant("T4_inv");

    // T5: asynchronous reset mid-cycle while events are in flight
    do_reset();
    for (int c = 0; c < 3; c++) step(1'b1, 1'b0);
    chk("T5_pre_pend", 0, pend_v[0], 1);
    drv_in = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check_zero("T5_async");
    drv_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("T5_hold");
    reset = 1'b0;
    clear_model();
    step(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) chk("T5_restart", i, out_v[i], 1);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) chk("T5_single", i, out_v[i], 0);

    // T6: MIN_GAP=1 passes a held input straight through
    do_reset();
    for (int c = 0; c < 24; c++) begin
      step(c < 20, 1'b0);
      c1 = c + 1;
      chk("T6_out", 3, out_v[3], c1 >= 1 && c1 <= 20);
      chk("T6_pend", 3, pend_v[3], 0);
    end
    check_invariant("T6_inv");

    // Random soak with varying density and occasional flush
    do_reset();
    for (int blk = 0; blk < 30; blk++) begin
      int dens;
      dens = int'($urandom_range(10, 100));
      for (int c = 0; c < 50; c++)
        step($urandom_range(1, 100) <= dens, $urandom_range(0, 99) < 3);
      check_invariant("soak_inv");
    end
    for (int c = 0; c < 60; c++) step(1'b0, 1'b0);
    check_zero("drain");
    check_invariant("final_inv");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
